// File: rtl/ring_buffer_sync.sv
// Single-clock circular FIFO between the filterbank producer and the UDP packetizer.
// Registered read port, occupancy count, and current/next-cycle empty and full flags.
module ring_buffer_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             emptied,
    output logic             empty_next,
    output logic             filled,
    output logic             full_next,
    output logic [AW:0]      fill_counter
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok = wr_en & ~filled;
    assign rd_ok = rd_en & ~emptied;

    always_comb begin
        count_nxt = count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    end

    assign empty_next   = (count_nxt == '0);
    assign full_next    = (count_nxt == FULL_COUNT);
    assign fill_counter = count;

    // Storage has no reset so it maps onto block RAM; stale contents are never readable.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            emptied  <= 1'b1;
            filled   <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            rd_valid <= rd_ok;
            count    <= count_nxt;
            emptied  <= (count_nxt == '0);
            filled   <= (count_nxt == FULL_COUNT);
        end
    end

endmodule

// File: tb/tb_ring_buffer_sync.sv
// Randomised scoreboard bench for ring_buffer_sync: a queue-based reference model
// predicts occupancy/flags, a monitor compares every presented read word.
module tb_ring_buffer_sync;

    localparam int WIDTH = 8;
    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             emptied;
    logic             empty_next;
    logic             filled;
    logic             full_next;
    logic [AW:0]      fill_counter;

    ring_buffer_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .emptied      (emptied),
        .empty_next   (empty_next),
        .filled       (filled),
        .full_next    (full_next),
        .fill_counter (fill_counter)
    );

    int compared   = 0;
    int mismatched = 0;
    int valid_cycles = 0;

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] last_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented read word must match the oldest expected word.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (rd_valid) begin
                    valid_cycles++;
                    if (exp_q.size() > 0) begin
                        last_data = exp_q.pop_front();
                        check("rd_data", 32'(rd_data), 32'(last_data));
                    end
                end else begin
                    check("rd_data_hold", 32'(rd_data), 32'(last_data));
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_q.delete();
        exp_q.delete();
        last_data = '0;
        #1;
        check("reset_emptied", 32'(emptied), 32'(1));
        check("reset_filled", 32'(filled), 32'(0));
        check("reset_count", 32'(fill_counter), 32'(0));
        check("reset_rd_valid", 32'(rd_valid), 32'(0));
        check("reset_rd_data", 32'(rd_data), 32'(0));
        #34;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic wr, input logic rd, input logic [WIDTH-1:0] data);
        bit wa;
        bit ra;
        int exp_cnt;
        wr_en   = wr;
        rd_en   = rd;
        wr_data = data;
        wa = wr && (model_q.size() < DEPTH);
        ra = rd && (model_q.size() > 0);
        exp_cnt = model_q.size() + int'(wa) - int'(ra);
        #1;
        check("empty_next", 32'(empty_next), 32'(exp_cnt == 0));
        check("full_next", 32'(full_next), 32'(exp_cnt == DEPTH));
        if (ra) exp_q.push_back(model_q.pop_front());
        if (wa) model_q.push_back(data);
        @(posedge clk);
        #1;
        check("fill_counter", 32'(fill_counter), 32'(model_q.size()));
        check("emptied", 32'(emptied), 32'(model_q.size() == 0));
        check("filled", 32'(filled), 32'(model_q.size() == DEPTH));
        check("rd_valid", 32'(rd_valid), 32'(ra));
    endtask

    logic [WIDTH-1:0] seq;

    initial begin
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        last_data = '0;
        #2;
        do_reset();

        // Fill with i[7:0]; the model flags full_next on the 1024th write.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, WIDTH'(i));
        check("fill_filled", 32'(filled), 32'(1));
        check("fill_count", 32'(fill_counter), 32'(DEPTH));
        step(1'b1, 1'b0, 8'hAA);
        check("overflow_count", 32'(fill_counter), 32'(DEPTH));

        // Drain for 1025 cycles: exactly 1024 valid words.
        valid_cycles = 0;
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        check("drain_valid_cycles", 32'(valid_cycles), 32'(DEPTH));
        check("drain_emptied", 32'(emptied), 32'(1));
        check("drain_count", 32'(fill_counter), 32'(0));

        // Preload 10, then simultaneous traffic across pointer wrap.
        seq = '0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, seq);
            seq++;
        end
        for (int i = 0; i < 2000; i++) begin
            step(1'b1, 1'b1, seq);
            seq++;
        end
        check("wrap_count", 32'(fill_counter), 32'(10));

        // Simultaneous access at full.
        while (model_q.size() < DEPTH) step(1'b1, 1'b0, WIDTH'($urandom));
        step(1'b1, 1'b1, 8'h11);
        check("full_both_count", 32'(fill_counter), 32'(DEPTH - 1));
        check("full_both_filled", 32'(filled), 32'(0));

        // Simultaneous access at empty: write only, no fall-through.
        while (model_q.size() > 0) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 8'h77);
        check("empty_both_count", 32'(fill_counter), 32'(1));
        check("empty_both_rd_valid", 32'(rd_valid), 32'(0));
        step(1'b0, 1'b1, '0);

        // Random traffic, biased in phases towards filling and draining.
        for (int i = 0; i < 3000; i++) begin
            if (i < 1500) step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), WIDTH'($urandom));
            else          step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), WIDTH'($urandom));
        end

        // Reset with 500 words stored, then a fresh write/read pair.
        do_reset();
        for (int i = 0; i < 500; i++) step(1'b1, 1'b0, WIDTH'($urandom));
        check("pre_reset_count", 32'(fill_counter), 32'(500));
        do_reset();
        step(1'b1, 1'b0, 8'h5C);
        step(1'b0, 1'b1, '0);
        check("post_reset_word", 32'(rd_data), 32'(8'h5C));
        step(1'b0, 1'b0, '0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
